mag_sequencer: RTL

- Drive-magnitude controller that sequences the brushless commutation datapath: produces the 12-bit drive magnitude it consumes.
- Soft-starts and slews the magnitude toward a requested target, one step per PWM period.
- Supervises hall sensors for stall and illegal sequences; on a fault, cuts drive and retries after a holdoff.
- Sits between the torque/assist computation (target_mag) and the commutator/PWM stage.

---
 rtl/mag_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mag_sequencer.sv
// rtl/mag_sequencer.sv - drive-magnitude sequencer with soft-start slew and hall supervision
//
// Purpose: slews a 12-bit drive magnitude toward target_mag one bounded step per
// PWM period, supervises hall sensors for illegal codes / out-of-order steps /
// stall, and on a fault cuts drive and auto-retries after a holdoff.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   PWM_synch  one-clk pulse per PWM period; gates slewing and hall sampling
//   enable     drive enable; low forces IDLE and clears a fault
//   brake_n    active-low brake; low forces drive off (does not leave FAULT)
//   target_mag requested magnitude, unsigned 12 bits
//   hallGrn/hallYlw/hallBlu  raw asynchronous hall inputs
//   drv_mag    registered drive magnitude
//   fault      high while in FAULT
//   state      IDLE=0, RAMP=1, RUN=2, FAULT=3

module mag_sequencer #(
  parameter int RAMP_STEP     = 16,
  parameter int STALL_PERIODS = 512,
  parameter int RETRY_PERIODS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PWM_synch,
  input  logic        enable,
  input  logic        brake_n,
  input  logic [11:0] target_mag,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  output logic [11:0] drv_mag,
  output logic        fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int SW = $clog2(STALL_PERIODS + 1);
  localparam int RW = $clog2(RETRY_PERIODS + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_PERIODS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_PERIODS - 1);
  localparam logic signed [12:0] STEP = 13'(RAMP_STEP);

  state_e        state_q, state_d;
  logic [11:0]   drv_mag_q, drv_mag_d;
  logic          fault_q, fault_d;
  logic [2:0]    hall_s1_q, hall_s2_q;
  logic [2:0]    hall_code_q, hall_code_d;
  logic          hall_vld_q, hall_vld_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;

  logic              drive_active;
  logic [2:0]        hall_new;
  logic              hall_change;
  logic              hall_illegal;
  logic              hall_adjacent;
  logic              hall_bad;
  logic              stall_hit;
  logic signed [12:0] mag_diff;
  logic [11:0]       mag_slew;

  // Forward step through the commutation cycle 101-100-110-010-011-001.
  // Illegal codes map to 000 so they never look adjacent to anything legal.
  function automatic logic [2:0] hall_fwd(input logic [2:0] c);
    case (c)
      3'b101:  hall_fwd = 3'b100;
      3'b100:  hall_fwd = 3'b110;
      3'b110:  hall_fwd = 3'b010;
      3'b010:  hall_fwd = 3'b011;
      3'b011:  hall_fwd = 3'b001;
      3'b001:  hall_fwd = 3'b101;
      default: hall_fwd = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] hall_rev(input logic [2:0] c);
    case (c)
      3'b101:  hall_rev = 3'b001;
      3'b001:  hall_rev = 3'b011;
      3'b011:  hall_rev = 3'b010;
      3'b010:  hall_rev = 3'b110;
      3'b110:  hall_rev = 3'b100;
      3'b100:  hall_rev = 3'b101;
      default: hall_rev = 3'b000;
    endcase
  endfunction

  assign drive_active  = (state_q == RAMP) || (state_q == RUN);
  assign hall_new      = hall_s2_q;
  assign hall_change   = (hall_new != hall_code_q);
  assign hall_illegal  = (hall_new == 3'b000) || (hall_new == 3'b111);
  assign hall_adjacent = (hall_fwd(hall_code_q) == hall_new) ||
                         (hall_rev(hall_code_q) == hall_new);
  // Out-of-order steps only count once a previous code has been captured.
  assign hall_bad      = PWM_synch &&
                         (hall_illegal || (hall_change && hall_vld_q && !hall_adjacent));
  assign stall_hit     = PWM_synch && !hall_change && (stall_cnt_q == STALL_MAX);

  // Signed 13-bit difference: the clamp below can neither wrap past 0xFFF
  // nor go negative, and lands exactly on the target instead of overshooting.
  always_comb begin
    mag_diff = $signed({1'b0, target_mag}) - $signed({1'b0, drv_mag_q});
    if (mag_diff > STEP) begin
      mag_slew = drv_mag_q + 12'(RAMP_STEP);
    end else if (mag_diff < -STEP) begin
      mag_slew = drv_mag_q - 12'(RAMP_STEP);
    end else begin
      mag_slew = target_mag;
    end
  end

  always_comb begin
    state_d     = state_q;
    drv_mag_d   = drv_mag_q;
    fault_d     = fault_q;
    stall_cnt_d = stall_cnt_q;
    retry_cnt_d = retry_cnt_q;
    hall_code_d = hall_code_q;
    hall_vld_d  = hall_vld_q;

    if (PWM_synch) begin
      hall_code_d = hall_new;
      hall_vld_d  = 1'b1;
    end

    // Outside RAMP/RUN the counter idles at zero, so IDLE->RAMP always starts fresh.
    if (!drive_active) begin
      stall_cnt_d = '0;
    end else if (PWM_synch) begin
      if (hall_change) begin
        stall_cnt_d = '0;
      end else if (stall_cnt_q != STALL_MAX) begin
        stall_cnt_d = stall_cnt_q + SW'(1);
      end
    end

    if (!enable) begin
      state_d   = IDLE;
      drv_mag_d = '0;
      fault_d   = 1'b0;
    end else if (!brake_n && (state_q != FAULT)) begin
      state_d   = IDLE;
      drv_mag_d = '0;
    end else if (drive_active && (hall_bad || stall_hit)) begin
      state_d     = FAULT;
      drv_mag_d   = '0;
      fault_d     = 1'b1;
      retry_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          drv_mag_d = '0;
          if (target_mag != 12'd0) begin
            state_d     = RAMP;
            stall_cnt_d = '0;
          end
        end
        RAMP: begin
          if ((target_mag == 12'd0) && (drv_mag_q == 12'd0)) begin
            state_d = IDLE;
          end else if (PWM_synch) begin
            drv_mag_d = mag_slew;
            if ((mag_slew == target_mag) && (target_mag != 12'd0)) begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if ((target_mag == 12'd0) && (drv_mag_q == 12'd0)) begin
            state_d = IDLE;
          end else if (PWM_synch) begin
            drv_mag_d = mag_slew;
          end
        end
        FAULT: begin
          drv_mag_d = '0;
          fault_d   = 1'b1;
          if (PWM_synch) begin
            if (retry_cnt_q == RETRY_MAX) begin
              state_d     = IDLE;
              fault_d     = 1'b0;
              retry_cnt_d = '0;
            end else begin
              retry_cnt_d = retry_cnt_q + RW'(1);
            end
          end
        end
        default: begin
          state_d   = IDLE;
          drv_mag_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drv_mag_q   <= '0;
      fault_q     <= 1'b0;
      hall_s1_q   <= '0;
      hall_s2_q   <= '0;
      hall_code_q <= '0;
      hall_vld_q  <= 1'b0;
      stall_cnt_q <= '0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drv_mag_q   <= drv_mag_d;
      fault_q     <= fault_d;
      hall_s1_q   <= {hallGrn, hallYlw, hallBlu};
      hall_s2_q   <= hall_s1_q;
      hall_code_q <= hall_code_d;
      hall_vld_q  <= hall_vld_d;
      stall_cnt_q <= stall_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign drv_mag = drv_mag_q;
  assign fault   = fault_q;
  assign state   = state_q;

endmodule
